watchdog_ctrl: RTL and testbench
================================

Name: watchdog_ctrl

Overview:
Programmable watchdog controller for the single-cycle SimpleRISC core. Detects PC stalls by comparing present_pc with previous_pc. Provides software configuration and a keyed kick, raises an early-warning interrupt, and sequences a fixed-length reset pulse back to the core. A register-mapped config port lets firmware enable the watchdog, lock its settings and service it.

Parameters:
CNT_W, 16, width of the stall counter and of the TIMEOUT/WARN registers
RST_PULSE, 4, number of cycles watchdog_rst stays high per bite (must be >=1)
KICK_KEY, 32'h5A5A_A5A5, value that must be written to the KICK address to service the watchdog

Ports:
clk  in  1  system clock, all state updates on its rising edge
rst  in  1  synchronous, active-high reset
present_pc  in  32  current core PC
previous_pc  in  32  PC of the previous cycle
cfg_we  in  1  config write strobe, single cycle
cfg_addr  in  2  register select: 0 CTRL, 1 TIMEOUT, 2 WARN, 3 KICK/COUNT
cfg_wdata  in  32  write data
cfg_rdata  out  32  combinational read data for cfg_addr
wdt_irq  out  1  early-warning level, high while in WARN
watchdog_rst  out  1  core reset request, high for exactly RST_PULSE cycles per bite
state_o  out  3  current FSM state encoding

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state IDLE(0), counter 0, enable 0, lock 0, TIMEOUT all-ones, WARN = 2^(CNT_W-1), pulse counter 0. Outputs wdt_irq=0, watchdog_rst=0, state_o=0.
- rst mid-pulse aborts the pulse immediately. rst has priority over every other event.
- progress = (present_pc != previous_pc). kick = cfg_we & cfg_addr==3 & cfg_wdata==KICK_KEY.
- badkick = cfg_we & cfg_addr==3 & cfg_wdata!=KICK_KEY.
- CTRL write: bit0 enable, bit1 lock (sticky; cleared only by rst). While lock=1, writes to CTRL/TIMEOUT/WARN are ignored.
- TIMEOUT/WARN take cfg_wdata[CNT_W-1:0]. A TIMEOUT write of 0 is ignored.
- Reads:
  - CTRL = {25'b0, state[2:0] at bits 6:4, 1'b0, wdt_irq, lock, enable}.
  - TIMEOUT/WARN are zero-extended.
  - addr 3 reads the counter, zero-extended.
- States: IDLE(0), COUNT(1), WARN(2), BITE(3), HOLD(4).
  - IDLE: counter held at 0. enable=1 -> COUNT.
  - COUNT/WARN: priority order, highest first:
    1. enable=0 -> IDLE, counter 0.
    2. badkick -> BITE.
    3. progress|kick -> COUNT, counter 0.
    4. counter>=TIMEOUT -> BITE.
    5. counter>=WARN -> WARN.
    6. else stay in the current state.
    Counter increments by 1 per cycle and saturates at TIMEOUT.
  - WARN>=TIMEOUT: WARN is skipped and the bite goes straight from COUNT.
  - BITE: watchdog_rst=1. The pulse counter counts RST_PULSE cycles, then -> HOLD. Kicks, progress, enable and badkick are ignored. The counter is cleared.
  - HOLD: one cycle with watchdog_rst=0 to let the PC settle, then -> COUNT if enable=1, else IDLE. enable and lock persist across a bite.
- watchdog_rst = (state==BITE); wdt_irq = (state==WARN). Both are decoded from the state register, so they are glitch-free.
- Latency: let s be the first non-progress cycle, with counter 0 at s. The counter equals TIMEOUT at s+TIMEOUT, and watchdog_rst is high over cycles s+TIMEOUT+1 .. s+TIMEOUT+RST_PULSE.
- Simultaneous events: a kick in the same cycle the counter hits TIMEOUT wins (no bite). A CTRL write clearing enable in the same cycle as a timeout wins (-> IDLE).

Test Plan:
1. Reset, enable=1, TIMEOUT=8, WARN=4, PC frozen from cycle s. Required: wdt_irq high from s+5; watchdog_rst high in cycles s+9..s+12 only; state_o=4 at s+13; state_o=1 at s+14.
2. Same config with PC changing every cycle for 100 cycles. Required: counter stays 0, wdt_irq=0, watchdog_rst=0 throughout.
3. PC frozen, kick with 32'h5A5A_A5A5 at counter=6 (WARN state). Required: state COUNT, wdt_irq low next cycle, counter 0. Then a kick with 32'h1234 -> watchdog_rst next cycle for 4 cycles.
4. Write lock=1, then write TIMEOUT=2 and CTRL=0. Required: readback TIMEOUT=8 and enable still 1. Write TIMEOUT=0 when unlocked -> readback unchanged.
5. Assert rst during the 2nd cycle of the bite. Required: watchdog_rst=0, state_o=0 and enable=0 on the following cycle, with all registers back to reset values.
6. WARN=20, TIMEOUT=8, PC frozen. Required: wdt_irq is never asserted, and the bite starts at s+9.

Source files
------------

// File: rtl/watchdog_ctrl.sv
// watchdog_ctrl: PC-stall watchdog with keyed kick, early-warning irq and fixed-length reset pulse.
// Register map: 0 CTRL, 1 TIMEOUT, 2 WARN, 3 KICK (write) / COUNT (read).
module watchdog_ctrl #(
    parameter int          CNT_W     = 16,
    parameter int          RST_PULSE = 4,
    parameter logic [31:0] KICK_KEY  = 32'h5A5A_A5A5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] present_pc,
    input  logic [31:0] previous_pc,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    output logic        wdt_irq,
    output logic        watchdog_rst,
    output logic [2:0]  state_o
);
    localparam int PW = $clog2(RST_PULSE + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        WARN  = 3'd2,
        BITE  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, r_timeout, r_warn;
    logic [PW-1:0]    r_pcnt;
    logic             r_en, r_lock;
    logic             w_progress, w_kick, w_badkick, w_ctrl_we, w_en;
    logic             w_active, w_nxt_active, w_pulse_done;

    assign w_progress   = present_pc != previous_pc;
    assign w_kick       = cfg_we && cfg_addr == 2'd3 && cfg_wdata == KICK_KEY;
    assign w_badkick    = cfg_we && cfg_addr == 2'd3 && cfg_wdata != KICK_KEY;
    assign w_ctrl_we    = cfg_we && cfg_addr == 2'd0 && !r_lock;
    // A same-cycle CTRL write overrides the stored enable so disabling beats a timeout
    assign w_en         = w_ctrl_we ? cfg_wdata[0] : r_en;
    assign w_active     = r_state == COUNT || r_state == WARN;
    assign w_nxt_active = w_state_nxt == COUNT || w_state_nxt == WARN;
    assign w_pulse_done = r_pcnt == PW'(RST_PULSE - 1);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:        w_state_nxt = w_en ? COUNT : IDLE;
            COUNT, WARN: w_state_nxt = !w_en                    ? IDLE  :
                                       w_badkick                ? BITE  :
                                       (w_progress || w_kick)   ? COUNT :
                                       (r_cnt >= r_timeout)     ? BITE  :
                                       (r_cnt >= r_warn)        ? WARN  : r_state;
            BITE:        w_state_nxt = w_pulse_done ? HOLD : BITE;
            HOLD:        w_state_nxt = w_en ? COUNT : IDLE;
            default:     w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        watchdog_rst = r_state == BITE;
        wdt_irq      = r_state == WARN;
        state_o      = r_state;
        cfg_rdata    = cfg_addr == 2'd0 ? {25'b0, r_state, 1'b0, r_state == WARN, r_lock, r_en} :
                       cfg_addr == 2'd1 ? 32'(r_timeout) :
                       cfg_addr == 2'd2 ? 32'(r_warn)    : 32'(r_cnt);
    end

    // Counter only runs while staying in COUNT/WARN without progress; it never passes TIMEOUT since that bites
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_pcnt    <= '0;
            r_en      <= 1'b0;
            r_lock    <= 1'b0;
            r_timeout <= '1;
            r_warn    <= CNT_W'(1) << (CNT_W - 1);
        end else begin
            r_cnt  <= (w_active && w_nxt_active && !(w_progress || w_kick)) ? r_cnt + 1'b1 : '0;
            r_pcnt <= (r_state == BITE && !w_pulse_done) ? r_pcnt + 1'b1 : '0;
            if (w_ctrl_we) begin
                r_en   <= cfg_wdata[0];
                r_lock <= cfg_wdata[1];
            end
            if (cfg_we && cfg_addr == 2'd1 && !r_lock && cfg_wdata[CNT_W-1:0] != '0)
                r_timeout <= cfg_wdata[CNT_W-1:0];
            if (cfg_we && cfg_addr == 2'd2 && !r_lock)
                r_warn <= cfg_wdata[CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_watchdog_ctrl.sv
// tb_watchdog_ctrl: directed stimulus against a cycle model of the watchdog rules, plus literal timing checks.
module tb_watchdog_ctrl;
    localparam logic [31:0] KEY = 32'h5A5A_A5A5;
    localparam int S_IDLE = 0, S_COUNT = 1, S_WARN = 2, S_BITE = 3, S_HOLD = 4;

    logic        clk = 1'b0;
    logic        rst, cfg_we, frz;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata, cfg_rdata, pc, present_pc, previous_pc;
    logic        wdt_irq, watchdog_rst;
    logic [2:0]  state_o;
    int          cyc = 0, n_chk = 0, n_fail = 0, s;

    int          m_mode, m_left;
    logic [15:0] m_cnt, m_to, m_wa;
    logic        m_en, m_lock, m_valid = 1'b0;
    logic        m_kick, m_bad, m_ctrl, m_prog, m_een;

    watchdog_ctrl dut (
        .clk(clk), .rst(rst), .present_pc(present_pc), .previous_pc(previous_pc),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .wdt_irq(wdt_irq), .watchdog_rst(watchdog_rst), .state_o(state_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (!frz) pc <= pc + 4;
    assign present_pc  = pc;
    assign previous_pc = frz ? pc : pc - 32'd4;

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d required < %0d", cyc, 5000);
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {25'b0, 3'(m_mode), 1'b0, m_mode == S_WARN, m_lock, m_en};
            2'd1:    return {16'b0, m_to};
            2'd2:    return {16'b0, m_wa};
            default: return {16'b0, m_cnt};
        endcase
    endfunction

    // Model: applies the documented per-cycle rules to the inputs sampled at this edge
    always @(posedge clk) begin
        if (rst) begin
            m_mode = S_IDLE; m_cnt = 0; m_en = 0; m_lock = 0; m_to = 16'hFFFF; m_wa = 16'h8000; m_left = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_kick = cfg_we && cfg_addr == 3 && cfg_wdata == KEY;
            m_bad  = cfg_we && cfg_addr == 3 && cfg_wdata != KEY;
            m_ctrl = cfg_we && cfg_addr == 0 && !m_lock;
            m_een  = m_ctrl ? cfg_wdata[0] : m_en;
            m_prog = present_pc != previous_pc;
            if (m_mode == S_IDLE) begin
                if (m_een) m_mode = S_COUNT;
            end else if (m_mode == S_COUNT || m_mode == S_WARN) begin
                if (!m_een) begin m_mode = S_IDLE; m_cnt = 0; end
                else if (m_bad || (!m_prog && !m_kick && m_cnt >= m_to)) begin
                    m_mode = S_BITE; m_left = 4; m_cnt = 0;
                end else if (m_prog || m_kick) begin m_mode = S_COUNT; m_cnt = 0; end
                else begin
                    if (m_cnt >= m_wa) m_mode = S_WARN;
                    m_cnt = (m_cnt + 1 > m_to) ? m_to : m_cnt + 1;
                end
            end else if (m_mode == S_BITE) begin
                m_left--;
                if (m_left == 0) m_mode = S_HOLD;
            end else m_mode = m_een ? S_COUNT : S_IDLE;
            if (m_ctrl) begin m_en = cfg_wdata[0]; m_lock = cfg_wdata[1]; end
            if (cfg_we && cfg_addr == 1 && !m_lock && cfg_wdata[15:0] != 0) m_to = cfg_wdata[15:0];
            if (cfg_we && cfg_addr == 2 && !m_lock) m_wa = cfg_wdata[15:0];
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_state", {29'b0, state_o}, 32'(m_mode));
            check("model_irq", {31'b0, wdt_irq}, {31'b0, m_mode == S_WARN});
            check("model_rst", {31'b0, watchdog_rst}, {31'b0, m_mode == S_BITE});
            check("model_rdata", cfg_rdata, exp_rd(cfg_addr));
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 0; cfg_addr = 3;
    endtask

    task automatic at(input int c);
        while (cyc < c) begin @(posedge clk); #1; end
        @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, input string nm, input logic [31:0] exp);
        cfg_addr = a; #1;
        check(nm, cfg_rdata, exp);
        cfg_addr = 3;
    endtask

    initial begin
        rst = 1; frz = 0; cfg_we = 0; cfg_addr = 3; cfg_wdata = 0; pc = 32'h100;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        check("reset_state", {29'b0, state_o}, 0);
        check("reset_outs", {30'b0, wdt_irq, watchdog_rst}, 0);
        rd(0, "reset_ctrl", 0);
        rd(1, "reset_timeout", 32'hFFFF);
        rd(2, "reset_warn", 32'h8000);
        rd(3, "reset_count", 0);
        // Stall to bite with TIMEOUT=8, WARN=4
        wr(1, 8); wr(2, 4); wr(0, 1);
        repeat (3) begin @(posedge clk); #1; end
        frz = 1; s = cyc;
        at(s + 4);  check("t1_irq_s4", {31'b0, wdt_irq}, 0); check("t1_cnt_s4", cfg_rdata, 4);
        at(s + 5);  check("t1_irq_s5", {31'b0, wdt_irq}, 1);
        at(s + 8);  check("t1_rst_s8", {31'b0, watchdog_rst}, 0); check("t1_cnt_s8", cfg_rdata, 8);
        at(s + 9);  check("t1_rst_s9", {31'b0, watchdog_rst}, 1); check("t1_st_s9", {29'b0, state_o}, 3);
        at(s + 12); check("t1_rst_s12", {31'b0, watchdog_rst}, 1);
        at(s + 13); check("t1_rst_s13", {31'b0, watchdog_rst}, 0); check("t1_st_s13", {29'b0, state_o}, 4);
        at(s + 14); check("t1_st_s14", {29'b0, state_o}, 1);
        frz = 0;
        // Continuous progress
        repeat (100) begin @(posedge clk); #1; end
        check("t2_cnt", cfg_rdata, 0);
        check("t2_outs", {30'b0, wdt_irq, watchdog_rst}, 0);
        // Good kick in WARN, then bad kick
        frz = 1; s = cyc;
        at(s + 6);  check("t3_cnt_s6", cfg_rdata, 6); check("t3_st_s6", {29'b0, state_o}, 2);
        cfg_we = 1; cfg_wdata = KEY;
        @(posedge clk); #1; cfg_we = 0;
        check("t3_kick_st", {29'b0, state_o}, 1);
        check("t3_kick_irq", {31'b0, wdt_irq}, 0);
        check("t3_kick_cnt", cfg_rdata, 0);
        cfg_we = 1; cfg_wdata = 32'h1234;
        @(posedge clk); #1; cfg_we = 0;
        check("t3_bad_rst", {31'b0, watchdog_rst}, 1);
        at(s + 11); check("t3_rst_last", {31'b0, watchdog_rst}, 1);
        at(s + 12); check("t3_rst_end", {31'b0, watchdog_rst}, 0); check("t3_hold", {29'b0, state_o}, 4);
        frz = 0;
        at(s + 13); check("t3_recount", {29'b0, state_o}, 1);
        // Lock
        wr(0, 3); wr(1, 2); wr(0, 0); wr(2, 1);
        rd(1, "t4_lock_timeout", 8);
        rd(2, "t4_lock_warn", 4);
        rd(0, "t4_lock_ctrl", 32'h13);
        // Reset during second bite cycle
        frz = 1; s = cyc;
        at(s + 10); check("t5_rst_s10", {31'b0, watchdog_rst}, 1);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        check("t5_after_rst", {31'b0, watchdog_rst}, 0);
        check("t5_state", {29'b0, state_o}, 0);
        rd(0, "t5_ctrl", 0);
        rd(1, "t5_timeout", 32'hFFFF);
        rd(2, "t5_warn", 32'h8000);
        rd(3, "t5_count", 0);
        frz = 0;
        wr(1, 8);
        rd(1, "t4_timeout8", 8);
        wr(1, 0);
        rd(1, "t4_timeout0_ignored", 8);
        // WARN >= TIMEOUT skips WARN
        wr(2, 20); wr(0, 1);
        repeat (2) begin @(posedge clk); #1; end
        frz = 1; s = cyc;
        for (int k = 0; k <= 8; k++) begin
            at(s + k);
            check("t6_quiet", {30'b0, wdt_irq, watchdog_rst}, 0);
        end
        at(s + 9);  check("t6_bite", {30'b0, wdt_irq, watchdog_rst}, 1);
        at(s + 12); check("t6_bite_last", {31'b0, watchdog_rst}, 1);
        at(s + 13); check("t6_bite_end", {31'b0, watchdog_rst}, 0);
        frz = 0;
        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
